// File: rtl/if_fetch_stage_if.sv
// Fetch-stage bus: debug/run control, hazard and redirect inputs, loader port and fetch outputs.
// The fetch stage connects through the slave modport; the driving side uses the master modport.
interface if_fetch_stage_if #(
    parameter int NB_INSTRUCT = 32,
    parameter int NB_PC       = 9
);
    logic                   i_start;
    logic                   i_step_en;
    logic                   i_PC_write;
    logic                   i_branch_taken;
    logic [NB_PC-1:0]       i_branch_target;
    logic                   i_jump;
    logic [NB_PC-1:0]       i_jump_target;
    logic                   i_mem_wr_en;
    logic [NB_PC-3:0]       i_mem_wr_addr;
    logic [NB_INSTRUCT-1:0] i_mem_wr_data;
    logic [NB_INSTRUCT-1:0] o_instruction;
    logic [NB_PC-1:0]       o_PC;
    logic [NB_PC-1:0]       o_PC_plus4;
    logic                   o_halt;
    logic                   o_running;
    logic [31:0]            o_fetch_count;

    modport master (
        output i_start, i_step_en, i_PC_write, i_branch_taken, i_branch_target,
               i_jump, i_jump_target, i_mem_wr_en, i_mem_wr_addr, i_mem_wr_data,
        input  o_instruction, o_PC, o_PC_plus4, o_halt, o_running, o_fetch_count
    );

    modport slave (
        input  i_start, i_step_en, i_PC_write, i_branch_taken, i_branch_target,
               i_jump, i_jump_target, i_mem_wr_en, i_mem_wr_addr, i_mem_wr_data,
        output o_instruction, o_PC, o_PC_plus4, o_halt, o_running, o_fetch_count
    );
endinterface

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC register, next-PC select, loader-written instruction memory, IDLE/RUN/HALT gate.
// Optional fetched-instruction counter enabled by defining FETCH_COUNTER_EN.
module if_fetch_stage #(
    parameter int                     NB_INSTRUCT = 32,
    parameter int                     NB_PC       = 9,
    parameter logic [NB_INSTRUCT-1:0] HALT_OPCODE = 32'hFFFF_FFFF
) (
    input  logic             i_clk,
    input  logic             i_reset,
    if_fetch_stage_if.slave  bus
);
    localparam int NB_WADDR = NB_PC - 2;
    localparam int DEPTH    = 1 << NB_WADDR;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_HALT = 2'b10
    } state_t;

    state_t                 state_r;
    state_t                 state_next_s;
    logic [NB_PC-1:0]       pc_r;
    logic [NB_PC-1:0]       pc_next_s;
    logic [NB_PC-1:0]       pc_plus4_s;
    logic [NB_PC-1:0]       branch_pc_s;
    logic [NB_PC-1:0]       jump_pc_s;
    logic [NB_INSTRUCT-1:0] mem_r [DEPTH];
    logic [NB_INSTRUCT-1:0] rd_word_s;
    logic                   fetch_s;
    logic                   is_halt_s;
    logic                   halt_r;
    logic                   running_r;
    logic                   unused_s;

    // Byte-offset bits of the redirect targets are discarded by word alignment.
    assign unused_s = ^{bus.i_branch_target[1:0], bus.i_jump_target[1:0]};

    assign pc_plus4_s  = pc_r + {{(NB_PC-3){1'b0}}, 3'b100};
    assign branch_pc_s = {bus.i_branch_target[NB_PC-1:2], 2'b00};
    assign jump_pc_s   = {bus.i_jump_target[NB_PC-1:2], 2'b00};
    assign rd_word_s   = mem_r[pc_r[NB_PC-1:2]];
    assign fetch_s     = (state_r == ST_RUN) && bus.i_step_en;
    assign is_halt_s   = (rd_word_s == HALT_OPCODE);

    // Loader port: memory is writable only while execution is not running.
    always_ff @(posedge i_clk) begin
        if (bus.i_mem_wr_en && (state_r != ST_RUN)) begin
            mem_r[bus.i_mem_wr_addr] <= bus.i_mem_wr_data;
        end
    end

    // Next-state and next-PC selection; HALT detection outranks any redirect.
    always_comb begin
        state_next_s = state_r;
        pc_next_s    = pc_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.i_start) begin
                    state_next_s = ST_RUN;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (!fetch_s) begin
                    state_next_s = ST_RUN;
                end else if (is_halt_s) begin
                    state_next_s = ST_HALT;
                end else if (bus.i_branch_taken) begin
                    pc_next_s = branch_pc_s;
                end else if (bus.i_jump) begin
                    pc_next_s = jump_pc_s;
                end else if (!bus.i_PC_write) begin
                    pc_next_s = pc_r;
                end else begin
                    pc_next_s = pc_plus4_s;
                end
            end
            ST_HALT: begin
                state_next_s = ST_HALT;
            end
            default: begin
                state_next_s = ST_IDLE;
                pc_next_s    = {NB_PC{1'b0}};
            end
        endcase
    end

    // State, PC and registered status flags.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_r   <= ST_IDLE;
            pc_r      <= {NB_PC{1'b0}};
            halt_r    <= 1'b0;
            running_r <= 1'b0;
        end else begin
            state_r   <= state_next_s;
            pc_r      <= pc_next_s;
            halt_r    <= (state_next_s == ST_HALT);
            running_r <= (state_next_s == ST_RUN);
        end
    end

    assign bus.o_instruction = (state_r == ST_RUN) ? rd_word_s : {NB_INSTRUCT{1'b0}};
    assign bus.o_PC          = pc_r;
    assign bus.o_PC_plus4    = pc_plus4_s;
    assign bus.o_halt        = halt_r;
    assign bus.o_running     = running_r;

`ifdef FETCH_COUNTER_EN
    logic        count_en_s;
    logic [31:0] fetch_count_r;

    // Stalled fetches do not count; redirects and the HALT fetch do.
    assign count_en_s = fetch_s &&
                        (is_halt_s || bus.i_branch_taken || bus.i_jump || bus.i_PC_write);

    // Saturating fetch counter.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            fetch_count_r <= 32'd0;
        end else if (count_en_s && (fetch_count_r != 32'hFFFF_FFFF)) begin
            fetch_count_r <= fetch_count_r + 32'd1;
        end
    end

    assign bus.o_fetch_count = fetch_count_r;
`else
    assign bus.o_fetch_count = 32'd0;
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Self-checking bench for if_fetch_stage: directed scenarios then randomized run against a behavioural model.
module tb_if_fetch_stage;
    localparam logic [31:0] HALT = 32'hFFFF_FFFF;

    logic i_clk;
    logic i_reset;

    if_fetch_stage_if #(.NB_INSTRUCT(32), .NB_PC(9)) bus ();

    if_fetch_stage #(.NB_INSTRUCT(32), .NB_PC(9), .HALT_OPCODE(32'hFFFF_FFFF)) dut (
        .i_clk  (i_clk),
        .i_reset(i_reset),
        .bus    (bus.slave)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Behavioural model: memory image, run/halt flags, byte PC, fetch count.
    logic [31:0] m_mem [128];
    bit          m_run;
    bit          m_halt;
    int unsigned m_pc;
    logic [31:0] m_count;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_count();
`ifdef FETCH_COUNTER_EN
        return m_count;
`else
        return 32'd0;
`endif
    endfunction

    function automatic void count_up();
        if (m_count != 32'hFFFF_FFFF) m_count = m_count + 32'd1;
    endfunction

    function automatic void model_update();
        logic [31:0] word;
        if (bus.i_mem_wr_en && !m_run) m_mem[bus.i_mem_wr_addr] = bus.i_mem_wr_data;
        if (i_reset) begin
            m_run = 0; m_halt = 0; m_pc = 0; m_count = 32'd0;
        end else if (!m_run && !m_halt) begin
            if (bus.i_start) m_run = 1;
        end else if (m_run && bus.i_step_en) begin
            word = m_mem[m_pc / 4];
            if (word == HALT) begin
                m_run = 0; m_halt = 1; count_up();
            end else if (bus.i_branch_taken) begin
                m_pc = 32'(bus.i_branch_target) & 32'h1FC; count_up();
            end else if (bus.i_jump) begin
                m_pc = 32'(bus.i_jump_target) & 32'h1FC; count_up();
            end else if (bus.i_PC_write) begin
                m_pc = (m_pc + 4) % 512; count_up();
            end
        end
    endfunction

    task automatic compare_all(input string tag);
        check({tag, "_pc"},    32'(bus.o_PC), m_pc);
        check({tag, "_pc4"},   32'(bus.o_PC_plus4), (m_pc + 4) % 512);
        check({tag, "_instr"}, bus.o_instruction, m_run ? m_mem[m_pc / 4] : 32'd0);
        check({tag, "_halt"},  32'(bus.o_halt), 32'(m_halt));
        check({tag, "_run"},   32'(bus.o_running), 32'(m_run));
        check({tag, "_cnt"},   bus.o_fetch_count, exp_count());
    endtask

    task automatic tick(input string tag);
        @(posedge i_clk);
        #1;
        model_update();
        compare_all(tag);
    endtask

    task automatic idle_inputs();
        bus.i_start = 0; bus.i_step_en = 1; bus.i_PC_write = 1;
        bus.i_branch_taken = 0; bus.i_branch_target = '0;
        bus.i_jump = 0; bus.i_jump_target = '0;
        bus.i_mem_wr_en = 0; bus.i_mem_wr_addr = '0; bus.i_mem_wr_data = '0;
    endtask

    task automatic load(input int addr, input logic [31:0] data);
        bus.i_mem_wr_en = 1; bus.i_mem_wr_addr = 7'(addr); bus.i_mem_wr_data = data;
        tick("load");
        bus.i_mem_wr_en = 0;
    endtask

    task automatic do_reset();
        i_reset = 1; tick("reset"); i_reset = 0;
    endtask

    task automatic do_start();
        bus.i_start = 1; tick("start"); bus.i_start = 0;
    endtask

    initial begin
        logic [31:0] saved_cnt;
        logic [31:0] w;
        m_run = 0; m_halt = 0; m_pc = 0; m_count = 32'd0;
        for (int i = 0; i < 128; i++) m_mem[i] = 32'd0;
        idle_inputs();
        i_reset = 1;
        #2;
        tick("rst0");
        i_reset = 0;
        check("rst_pc", 32'(bus.o_PC), 32'd0);
        check("rst_run", 32'(bus.o_running), 32'd0);

        for (int i = 0; i < 128; i++) begin
            w = $urandom();
            if (w == HALT) w = 32'd0;
            load(i, w);
        end
        load(0, 32'h2001_0001); load(1, 32'h2002_0002);
        load(2, 32'h2003_0003); load(3, HALT);

        // Straight-line program ending in HALT
        do_start();
        check("tp1_pc0", 32'(bus.o_PC), 32'd0);
        tick("tp1"); check("tp1_pc4", 32'(bus.o_PC), 32'd4);
        tick("tp1"); check("tp1_pc8", 32'(bus.o_PC), 32'd8);
        tick("tp1"); check("tp1_pc12", 32'(bus.o_PC), 32'd12);
        check("tp1_haltword", bus.o_instruction, HALT);
        tick("tp1");
        check("tp1_halt", 32'(bus.o_halt), 32'd1);
        check("tp1_haltpc", 32'(bus.o_PC), 32'd12);
        bus.i_start = 1; tick("tp1_ign"); bus.i_start = 0;
        check("tp1_stay", 32'(bus.o_halt), 32'd1);

        // Stall at PC=8
        do_reset();
        load(3, 32'h2004_0004);
        do_start(); tick("tp2"); tick("tp2");
        saved_cnt = bus.o_fetch_count;
        bus.i_PC_write = 0;
        tick("tp2s"); check("tp2_hold1", 32'(bus.o_PC), 32'd8);
        tick("tp2s"); check("tp2_hold2", 32'(bus.o_PC), 32'd8);
        check("tp2_cnt", bus.o_fetch_count, saved_cnt);
        bus.i_PC_write = 1;
        tick("tp2"); check("tp2_resume", 32'(bus.o_PC), 32'd12);

        // Branch outranks jump and stall
        do_reset(); do_start(); tick("tp3");
        bus.i_branch_taken = 1; bus.i_branch_target = 9'h041;
        bus.i_jump = 1; bus.i_jump_target = 9'h080; bus.i_PC_write = 0;
        tick("tp3"); check("tp3_branch", 32'(bus.o_PC), 32'h40);
        idle_inputs();

        // Wrap at the last word
        bus.i_jump = 1; bus.i_jump_target = 9'h1FC;
        tick("tp4"); idle_inputs();
        check("tp4_pc4wrap", 32'(bus.o_PC_plus4), 32'd0);
        tick("tp4"); check("tp4_wrap", 32'(bus.o_PC), 32'd0);

        // Writes during RUN are ignored
        bus.i_mem_wr_en = 1; bus.i_mem_wr_addr = 7'd1; bus.i_mem_wr_data = 32'hDEAD_BEEF;
        tick("tp5"); idle_inputs();
        check("tp5_nowrite", bus.o_instruction, 32'h2002_0002);
        do_reset(); load(1, 32'hDEAD_BEEF); do_start(); tick("tp5");
        check("tp5_loaded", bus.o_instruction, 32'hDEAD_BEEF);

        // Step freeze, then reset at PC=0x10
        bus.i_step_en = 0;
        tick("frz"); tick("frz");
        check("frz_pc", 32'(bus.o_PC), 32'd4);
        bus.i_step_en = 1;
        tick("tp6"); tick("tp6"); tick("tp6");
        check("tp6_pc10", 32'(bus.o_PC), 32'h10);
        do_reset();
        check("tp6_pc", 32'(bus.o_PC), 32'd0);
        check("tp6_instr", bus.o_instruction, 32'd0);
        check("tp6_halt", 32'(bus.o_halt), 32'd0);
        do_start();
        check("tp6_prog", bus.o_instruction, 32'h2001_0001);

        // Randomized rounds
        for (int r = 0; r < 10; r++) begin
            do_reset();
            for (int k = 0; k < 8; k++) begin
                w = ($urandom_range(0, 7) == 0) ? HALT : $urandom();
                load(int'($urandom_range(0, 127)), w);
            end
            do_start();
            for (int c = 0; c < 50; c++) begin
                bus.i_step_en      = ($urandom_range(0, 3) != 0);
                bus.i_PC_write     = ($urandom_range(0, 3) != 0);
                bus.i_branch_taken = ($urandom_range(0, 7) == 0);
                bus.i_branch_target = 9'($urandom());
                bus.i_jump         = ($urandom_range(0, 7) == 0);
                bus.i_jump_target  = 9'($urandom());
                bus.i_start        = ($urandom_range(0, 15) == 0);
                bus.i_mem_wr_en    = ($urandom_range(0, 7) == 0);
                bus.i_mem_wr_addr  = 7'($urandom());
                bus.i_mem_wr_data  = $urandom();
                tick("rnd");
            end
            idle_inputs();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
Instruction-fetch stage of the 5-stage pipeline, directly upstream of the IF/ID pipeline register.
- Holds the PC register, selects the next PC (sequential, branch, jump, stall) and reads instruction memory combinationally.
- The debug loader writes instruction memory before execution.
- A small FSM gates execution: IDLE (program load), RUN, HALT (HALT instruction fetched).

Parameters:
- NB_INSTRUCT, 32: instruction width.
- NB_PC, 9: PC width; byte address; memory holds 2^(NB_PC-2) words.
- HALT_OPCODE, 32'hFFFF_FFFF: instruction encoding that stops fetch.

Ports:
- i_clk, input, 1: clock, rising edge.
- i_reset, input, 1: synchronous, active-high reset.
- i_start, input, 1: one-cycle pulse; IDLE->RUN.
- i_step_en, input, 1: advance enable from debug unit; 1 = free run.
- i_PC_write, input, 1: hazard unit; 0 = stall PC.
- i_branch_taken, input, 1: redirect to i_branch_target.
- i_branch_target, input, NB_PC: branch target byte address.
- i_jump, input, 1: redirect to i_jump_target.
- i_jump_target, input, NB_PC: jump target byte address.
- i_mem_wr_en, input, 1: loader write strobe.
- i_mem_wr_addr, input, NB_PC-2: word address.
- i_mem_wr_data, input, NB_INSTRUCT: word to store.
- o_instruction, output, NB_INSTRUCT: instruction at o_PC; 0 when not RUN.
- o_PC, output, NB_PC: current PC.
- o_PC_plus4, output, NB_PC: o_PC+4.
- o_halt, output, 1: high in HALT.
- o_running, output, 1: high in RUN.
- o_fetch_count, output, 32: fetched-instruction count (optional feature).

Behaviour:
Interface:
- Clock i_clk. Reset i_reset, synchronous, active-high.

Reset:
- state=IDLE, PC=0, o_halt=0, o_running=0, o_fetch_count=0.
- Instruction memory contents are NOT cleared by reset.

Memory:
- Synchronous write on i_clk when i_mem_wr_en=1 and state!=RUN; writes during RUN are ignored.
- Combinational read at word index PC[NB_PC-1:2].
- o_instruction is the read word in RUN and 0 (NOP) in IDLE/HALT, so the IF/ID register captures a bubble.

FSM:
- IDLE: PC held. i_start=1 -> RUN next cycle, PC stays 0.
- RUN: a fetch occurs each cycle with i_step_en=1. If the fetched word == HALT_OPCODE -> HALT next cycle; the HALT word is still presented on o_instruction that cycle so it drains down the pipe.
- HALT: PC frozen at the HALT address. Only i_reset leaves HALT; i_start is ignored.

Next PC (RUN and i_step_en=1 only), priority high to low:
1. i_branch_taken -> {i_branch_target[NB_PC-1:2],2'b00}.
2. i_jump -> {i_jump_target[NB_PC-1:2],2'b00}.
3. i_PC_write=0 -> hold.
4. PC+4, wrapping modulo 2^NB_PC (last word -> 0).

Simultaneous events:
- A redirect overrides a stall in the same cycle.
- A redirect on the same cycle as HALT detection: HALT wins, PC frozen.

Other rules:
- i_step_en=0 freezes PC and FSM; o_instruction still shows the word at PC.
- o_PC_plus4 is combinational from the PC register, same wrap rule.
- Latency: a PC update is visible one cycle after the selecting inputs are sampled.
- Reset during RUN returns to IDLE with PC=0 on the next edge; loaded program is retained.

Optional Feature:
Macro: FETCH_COUNTER_EN.
- Defined: 32-bit counter increments on every RUN cycle with i_step_en=1 and a PC update (stall cycles excluded, redirects included). HALT fetch counts. Saturates at 32'hFFFF_FFFF. Cleared by reset.
- Undefined: no counter logic; o_fetch_count tied to 0.

Test Plan:
1. Load words 0..3 = 0x20010001, 0x20020002, 0x20030003, 0xFFFFFFFF; pulse i_start. Expected:
   - o_PC = 0, 4, 8, 12 on consecutive cycles.
   - o_halt=1 from the cycle after PC=12, PC stays 12.
   - o_fetch_count=4 (macro defined).
2. In RUN at PC=8, assert i_PC_write=0 for 2 cycles. Expected:
   - PC holds 8 for 2 cycles, then 12.
   - Count unchanged during the stall.
3. At PC=4, assert i_branch_taken=1, target=0x41, with i_jump=1, target=0x80, and i_PC_write=0. Expected: next PC=0x40.
4. PC=0x1FC with sequential fetch. Expected:
   - next PC=0x000, o_PC_plus4=0x000 at PC=0x1FC.
5. During RUN, write i_mem_wr_addr=1, data=0xDEADBEEF. Expected:
   - Memory unchanged.
   - After reset and re-load in IDLE, word 1 reads 0xDEADBEEF at PC=4.
6. i_reset at PC=0x10 in RUN. Expected:
   - Next cycle PC=0, state IDLE, o_instruction=0, o_halt=0.
   - Program still present after the next i_start.
